mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit of the 5-stage RISC-V pipeline.
- Consumes the registered EX/MEM bundle and drives the data-memory bus with a req/ready handshake.
- Aligns store data and byte enables; sign- or zero-extends load data.
- Stalls upstream while a memory access is outstanding and registers the MEM/WB bundle for writeback.

---
 rtl/mem_stage_lsu.sv | 173 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives the data-memory bus through a req/ready
// handshake, aligns stores, extends loads and registers the MEM/WB bundle.
module mem_stage_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            em_valid,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_index,
  input  logic [3:0]      dm_w_en,
  input  logic            wb_sel,
  input  logic            wb_en,
  input  logic            halt,
  input  logic [2:0]      func3,
  output logic            dm_req,
  output logic            dm_we,
  output logic [XLEN-1:0] dm_addr,
  output logic [XLEN-1:0] dm_wdata,
  output logic [3:0]      dm_be,
  input  logic            dm_ready,
  input  logic [XLEN-1:0] dm_rdata,
  output logic            stall,
  output logic            mw_valid,
  output logic [XLEN-1:0] mw_wb_data,
  output logic [4:0]      mw_rd_index,
  output logic            mw_wb_en,
  output logic            mw_halt,
  output logic            misalign_exc
);

  // Bus handshake: dm_req is held with stable addr/we/wdata/be for the whole
  // BUSY period; the transfer completes at the first edge where dm_ready=1.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]      state;
  logic            halted;
  logic [XLEN-1:0] l_addr;
  logic [XLEN-1:0] l_wdata;
  logic [3:0]      l_be;
  logic            l_we;
  logic            l_load;
  logic [4:0]      l_rd;
  logic [2:0]      l_func3;
  logic            l_wb_en;
  logic            l_halt;

  logic            is_store;
  logic            memop;
  logic [1:0]      acc_size;
  logic            misaligned;
  logic            halting;
  logic            start;
  logic            to_mw;
  logic [XLEN-1:0] lane_byte;
  logic [15:0]     lane_half;
  logic [XLEN-1:0] load_data;

  assign is_store = |dm_w_en;
  assign memop    = em_valid & (wb_sel | is_store);

  // Access size: 0 byte, 1 half, 2 word; stores take it from the mask.
  always_comb begin
    acc_size = 2'd0;
    if (is_store) begin
      case (dm_w_en)
        4'b0011: acc_size = 2'd1;
        4'b1111: acc_size = 2'd2;
        default: acc_size = 2'd0;
      endcase
    end else begin
      case (func3[1:0])
        2'b00:   acc_size = 2'd0;
        2'b01:   acc_size = 2'd1;
        default: acc_size = 2'd2;
      endcase
    end
  end

  assign misaligned = ((acc_size == 2'd1) & alu_out[0]) |
                      ((acc_size == 2'd2) & (|alu_out[1:0]));
  // A halt sitting in MW freezes intake the same cycle it retires.
  assign halting    = halted | mw_halt;
  assign start      = (state == IDLE) & ~halting & memop & ~misaligned;
  assign to_mw      = em_valid & ~(memop & ~misaligned);

  assign stall    = rst & (halting | start | ((state == BUSY) & ~dm_ready));
  assign dm_req   = (state == BUSY);
  assign dm_we    = dm_req & l_we;
  assign dm_addr  = {l_addr[XLEN-1:2], 2'b00};
  assign dm_wdata = l_wdata;
  assign dm_be    = l_be;

  assign lane_byte = dm_rdata >> {l_addr[1:0], 3'b000};
  assign lane_half = l_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    load_data = dm_rdata;
    case (l_func3)
      3'b000:  load_data = {{(XLEN-8){lane_byte[7]}}, lane_byte[7:0]};
      3'b001:  load_data = {{(XLEN-16){lane_half[15]}}, lane_half};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, lane_byte[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, lane_half};
      default: load_data = dm_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      halted       <= 1'b0;
      l_addr       <= '0;
      l_wdata      <= '0;
      l_be         <= '0;
      l_we         <= 1'b0;
      l_load       <= 1'b0;
      l_rd         <= '0;
      l_func3      <= '0;
      l_wb_en      <= 1'b0;
      l_halt       <= 1'b0;
      mw_valid     <= 1'b0;
      mw_wb_data   <= '0;
      mw_rd_index  <= '0;
      mw_wb_en     <= 1'b0;
      mw_halt      <= 1'b0;
      misalign_exc <= 1'b0;
    end else begin
      halted <= halted | mw_halt;
      if (state == BUSY) begin
        misalign_exc <= 1'b0;
        if (dm_ready) begin
          state       <= IDLE;
          mw_valid    <= 1'b1;
          mw_wb_data  <= l_load ? load_data : l_addr;
          mw_rd_index <= l_rd;
          mw_wb_en    <= l_wb_en;
          mw_halt     <= l_halt;
        end else begin
          mw_valid <= 1'b0;
          mw_wb_en <= 1'b0;
          mw_halt  <= 1'b0;
        end
      end else if (halting) begin
        mw_valid     <= 1'b0;
        mw_wb_en     <= 1'b0;
        mw_halt      <= 1'b0;
        misalign_exc <= 1'b0;
      end else begin
        mw_valid     <= to_mw;
        mw_wb_data   <= alu_out;
        mw_rd_index  <= rd_index;
        mw_wb_en     <= em_valid & ~memop & wb_en;
        mw_halt      <= to_mw & halt;
        misalign_exc <= memop & misaligned;
        if (start) begin
          state   <= BUSY;
          l_addr  <= alu_out;
          l_wdata <= rs2_data << {alu_out[1:0], 3'b000};
          l_be    <= dm_w_en << alu_out[1:0];
          l_we    <= is_store;
          l_load  <= wb_sel & ~is_store;
          l_rd    <= rd_index;
          l_func3 <= func3;
          l_wb_en <= wb_en;
          l_halt  <= halt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: vector table for single accesses plus
// hand-written sequences for reset-during-access and halt.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        em_valid;
  logic [31:0] alu_out;
  logic [31:0] rs2_data;
  logic [4:0]  rd_index;
  logic [3:0]  dm_w_en;
  logic        wb_sel;
  logic        wb_en;
  logic        halt;
  logic [2:0]  func3;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        stall;
  logic        mw_valid;
  logic [31:0] mw_wb_data;
  logic [4:0]  mw_rd_index;
  logic        mw_wb_en;
  logic        mw_halt;
  logic        misalign_exc;

  int tests = 0;
  int fails = 0;

  mem_stage_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .em_valid(em_valid), .alu_out(alu_out),
    .rs2_data(rs2_data), .rd_index(rd_index), .dm_w_en(dm_w_en),
    .wb_sel(wb_sel), .wb_en(wb_en), .halt(halt), .func3(func3),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ready(dm_ready), .dm_rdata(dm_rdata), .stall(stall),
    .mw_valid(mw_valid), .mw_wb_data(mw_wb_data), .mw_rd_index(mw_rd_index),
    .mw_wb_en(mw_wb_en), .mw_halt(mw_halt), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  // kind: 0 = ALU op, 1 = aligned memory access, 2 = misaligned access
  typedef struct {
    string       name;
    int          kind;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [3:0]  w_en;
    logic        wb_sel;
    logic        wb_en;
    logic [2:0]  f3;
    logic [4:0]  rd;
    int          waits;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input int kind, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [3:0] w_en, input logic wbs,
                         input logic wbe, input logic [2:0] f3, input logic [4:0] rd,
                         input int waits, input logic [31:0] rdata, input logic [31:0] e_addr,
                         input logic [3:0] e_be, input logic [31:0] e_wdata,
                         input logic [31:0] e_wb);
    vec_t v;
    v.name = name; v.kind = kind; v.addr = addr; v.rs2 = rs2; v.w_en = w_en;
    v.wb_sel = wbs; v.wb_en = wbe; v.f3 = f3; v.rd = rd; v.waits = waits;
    v.rdata = rdata; v.exp_addr = e_addr; v.exp_be = e_be;
    v.exp_wdata = e_wdata; v.exp_wb = e_wb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_em();
    em_valid = 1'b0; alu_out = '0; rs2_data = '0; rd_index = '0; dm_w_en = '0;
    wb_sel = 1'b0; wb_en = 1'b0; halt = 1'b0; func3 = '0;
  endtask

  task automatic drive_em(input vec_t v);
    em_valid = 1'b1; alu_out = v.addr; rs2_data = v.rs2; rd_index = v.rd;
    dm_w_en = v.w_en; wb_sel = v.wb_sel; wb_en = v.wb_en; halt = 1'b0; func3 = v.f3;
  endtask

  task automatic run_alu(input vec_t v);
    drive_em(v);
    @(negedge clk);
    check({v.name, " stall"}, 32'(stall), 32'd0);
    tick();
    check({v.name, " mw_valid"}, 32'(mw_valid), 32'd1);
    check({v.name, " wb_data"}, mw_wb_data, v.exp_wb);
    check({v.name, " rd"}, 32'(mw_rd_index), 32'(v.rd));
    check({v.name, " wb_en"}, 32'(mw_wb_en), 32'(v.wb_en));
    clear_em();
    tick();
    check({v.name, " bubble"}, 32'(mw_valid), 32'd0);
  endtask

  task automatic run_mis(input vec_t v);
    drive_em(v);
    @(negedge clk);
    check({v.name, " stall"}, 32'(stall), 32'd0);
    check({v.name, " req idle"}, 32'(dm_req), 32'd0);
    tick();
    check({v.name, " mw_valid"}, 32'(mw_valid), 32'd1);
    check({v.name, " wb_en"}, 32'(mw_wb_en), 32'd0);
    check({v.name, " exc"}, 32'(misalign_exc), 32'd1);
    check({v.name, " req"}, 32'(dm_req), 32'd0);
    clear_em();
    tick();
    check({v.name, " exc pulse"}, 32'(misalign_exc), 32'd0);
    check({v.name, " req after"}, 32'(dm_req), 32'd0);
  endtask

  task automatic run_mem(input vec_t v);
    int stall_cnt;
    stall_cnt = 0;
    drive_em(v);
    @(negedge clk);
    if (stall) stall_cnt++;
    check({v.name, " req idle"}, 32'(dm_req), 32'd0);
    tick();
    // Scrambled EX/MEM inputs during BUSY must not leak onto the bus.
    em_valid = 1'b0; alu_out = 32'hFFFF_FFFF; rs2_data = 32'h5555_5555;
    dm_w_en = 4'hF; func3 = 3'b111; rd_index = 5'd31;
    for (int k = 0; k <= v.waits; k++) begin
      if (k == v.waits) begin
        dm_ready = 1'b1;
        dm_rdata = v.rdata;
      end else begin
        dm_rdata = 32'hDEAD_0000 | 32'(k);
      end
      @(negedge clk);
      if (stall) stall_cnt++;
      check({v.name, " req"}, 32'(dm_req), 32'd1);
      check({v.name, " addr"}, dm_addr, v.exp_addr);
      check({v.name, " be"}, 32'(dm_be), 32'(v.exp_be));
      check({v.name, " we"}, 32'(dm_we), 32'(v.w_en != 4'd0));
      if (v.w_en != 4'd0) check({v.name, " wdata"}, dm_wdata, v.exp_wdata);
      check({v.name, " mw_valid busy"}, 32'(mw_valid), 32'd0);
      tick();
    end
    dm_ready = 1'b0;
    clear_em();
    check({v.name, " mw_valid"}, 32'(mw_valid), 32'd1);
    if (v.wb_sel) check({v.name, " wb_data"}, mw_wb_data, v.exp_wb);
    check({v.name, " rd"}, 32'(mw_rd_index), 32'(v.rd));
    check({v.name, " wb_en"}, 32'(mw_wb_en), 32'(v.wb_en));
    check({v.name, " stall cycles"}, 32'(stall_cnt), 32'(v.waits + 1));
    @(negedge clk);
    check({v.name, " req done"}, 32'(dm_req), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    dm_ready = 1'b0;
    dm_rdata = '0;
    clear_em();

    //      name          kind addr          rs2           w_en wbs wbe f3 rd wt rdata         e_addr        e_be     e_wdata       e_wb
    add_vec("alu",        0, 32'h0000_1234, 32'h0,        4'h0, 0, 1, 3'd0, 5, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_1234);
    add_vec("alu2",       0, 32'hA5A5_0F0F, 32'h0,        4'h0, 0, 1, 3'd0, 9, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hA5A5_0F0F);
    add_vec("sb",         1, 32'h0000_0103, 32'h0000_00AB, 4'h1, 0, 0, 3'd0, 0, 0, 32'h0,        32'h0000_0100, 4'b1000, 32'hAB00_0000, 32'h0);
    add_vec("sh",         1, 32'h0000_0202, 32'h1234_BEEF, 4'h3, 0, 0, 3'd1, 0, 1, 32'h0,        32'h0000_0200, 4'b1100, 32'hBEEF_0000, 32'h0);
    add_vec("sw",         1, 32'h0000_02F0, 32'hDEAD_BEEF, 4'hF, 0, 0, 3'd2, 0, 2, 32'h0,        32'h0000_02F0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    add_vec("lb",         1, 32'h0000_0202, 32'h0,        4'h0, 1, 1, 3'd0, 3, 3, 32'h0080_0000, 32'h0000_0200, 4'b0000, 32'h0,        32'hFFFF_FF80);
    add_vec("lbu",        1, 32'h0000_0202, 32'h0,        4'h0, 1, 1, 3'd4, 4, 3, 32'h0080_0000, 32'h0000_0200, 4'b0000, 32'h0,        32'h0000_0080);
    add_vec("lb lane1",   1, 32'h0000_0001, 32'h0,        4'h0, 1, 1, 3'd0, 6, 0, 32'h0000_7F00, 32'h0000_0000, 4'b0000, 32'h0,        32'h0000_007F);
    add_vec("lh",         1, 32'h0000_0206, 32'h0,        4'h0, 1, 1, 3'd1, 10, 1, 32'h8001_1234, 32'h0000_0204, 4'b0000, 32'h0,       32'hFFFF_8001);
    add_vec("lhu",        1, 32'h0000_0206, 32'h0,        4'h0, 1, 1, 3'd5, 11, 0, 32'h8001_1234, 32'h0000_0204, 4'b0000, 32'h0,       32'h0000_8001);
    add_vec("lw",         1, 32'h0000_0400, 32'h0,        4'h0, 1, 1, 3'd2, 12, 0, 32'hCAFE_F00D, 32'h0000_0400, 4'b0000, 32'h0,       32'hCAFE_F00D);
    add_vec("f3 011",     1, 32'h0000_0404, 32'h0,        4'h0, 1, 1, 3'd3, 13, 1, 32'h1234_5678, 32'h0000_0404, 4'b0000, 32'h0,       32'h1234_5678);
    add_vec("mis lw",     2, 32'h0000_0301, 32'h0,        4'h0, 1, 1, 3'd2, 14, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0);
    add_vec("mis sh",     2, 32'h0000_0105, 32'h0000_BEEF, 4'h3, 0, 0, 3'd1, 0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0);
    add_vec("mis lh",     2, 32'h0000_0107, 32'h0,        4'h0, 1, 1, 3'd5, 15, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0);

    tick();
    tick();
    check("reset req", 32'(dm_req), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset mw_valid", 32'(mw_valid), 32'd0);
    check("reset wb_data", mw_wb_data, 32'd0);
    check("reset exc", 32'(misalign_exc), 32'd0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        0:       run_alu(vecs[i]);
        1:       run_mem(vecs[i]);
        default: run_mis(vecs[i]);
      endcase
    end

    // Reset during the second BUSY cycle abandons the access.
    drive_em(vecs[10]);
    tick();
    tick();
    check("rst mid busy req before", 32'(dm_req), 32'd1);
    rst = 1'b0;
    #1;
    check("rst mid busy req", 32'(dm_req), 32'd0);
    check("rst mid busy stall", 32'(stall), 32'd0);
    check("rst mid busy we", 32'(dm_we), 32'd0);
    check("rst mid busy addr", dm_addr, 32'd0);
    check("rst mid busy be", 32'(dm_be), 32'd0);
    check("rst mid busy mw_valid", 32'(mw_valid), 32'd0);
    clear_em();
    tick();
    rst = 1'b1;
    tick();
    run_mem(vecs[10]);

    // Halt retires once, then the stage stays frozen until reset.
    em_valid = 1'b1; alu_out = 32'h77; rd_index = 5'd7; wb_en = 1'b1; halt = 1'b1;
    tick();
    check("halt mw_valid", 32'(mw_valid), 32'd1);
    check("halt mw_halt", 32'(mw_halt), 32'd1);
    check("halt wb_data", mw_wb_data, 32'h77);
    drive_em(vecs[1]);
    @(negedge clk);
    check("halt retire stall", 32'(stall), 32'd1);
    tick();
    check("halt pulse", 32'(mw_halt), 32'd0);
    check("halted mw_valid", 32'(mw_valid), 32'd0);
    check("halted stall", 32'(stall), 32'd1);
    drive_em(vecs[10]);
    dm_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("halted req", 32'(dm_req), 32'd0);
      check("halted stall loop", 32'(stall), 32'd1);
      tick();
      check("halted mw_valid loop", 32'(mw_valid), 32'd0);
      check("halted mw_halt loop", 32'(mw_halt), 32'd0);
    end
    dm_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("halt reset stall", 32'(stall), 32'd0);
    clear_em();
    tick();
    rst = 1'b1;
    tick();
    run_alu(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
